// File: rtl/vga_bus_pkg.sv
// Package: vga_bus_pkg
// Shared definitions for the VGA peripheral register map and for the bus
// master that drives it. The VGA peripheral decodes the same offsets, so the
// register layout lives here and nowhere else.
//   VGA_BASE_ADDR        default register base
//   VGA_X/Y/D_OFS        offsets of the X, Y and DATA registers from the base
//   VGA_X_MAX/VGA_Y_MAX  highest legal pixel coordinates
//   wr_state_e           write-sequencer states
//   pixel_req_t          one queued pixel request {x, y, pixel}
package vga_bus_pkg;

    localparam logic [7:0] VGA_BASE_ADDR = 8'hB0;
    localparam logic [7:0] VGA_X_OFS     = 8'd0;
    localparam logic [7:0] VGA_Y_OFS     = 8'd1;
    localparam logic [7:0] VGA_D_OFS     = 8'd2;
    localparam logic [7:0] VGA_X_MAX     = 8'd159;
    localparam logic [6:0] VGA_Y_MAX     = 7'd119;
    localparam int         REQ_W         = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR_X = 2'd1,
        ST_WR_Y = 2'd2,
        ST_WR_D = 2'd3
    } wr_state_e;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic       pixel;
    } pixel_req_t;

    // True when the coordinate pair addresses a visible pixel.
    function automatic logic req_in_range(input logic [7:0] x, input logic [6:0] y,
                                          input logic [7:0] x_max, input logic [6:0] y_max);
        return (x <= x_max) && (y <= y_max);
    endfunction

endpackage

// File: rtl/pixel_req_fifo.sv
// Module: pixel_req_fifo
// Synchronous FIFO holding pending pixel requests. The head entry is visible
// on pop_data whenever empty is low (show-ahead). Pointers carry one extra
// wrap bit so full and empty are distinguished without a separate counter.
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   push         write push_data when not full (ignored when full)
//   pop          advance the head when not empty (ignored when empty)
//   pop_data     current head entry
//   full, empty  occupancy flags, derived from registered pointers only
module pixel_req_fifo
    import vga_bus_pkg::*;
#(
    parameter int WIDTH = REQ_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; a push and a pop in the same cycle leave occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage write; cleared on reset so the head never presents unknown data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/vga_pixel_bus_master.sv
// Module: vga_pixel_bus_master
// Bus initiator that turns pixel requests into VGA register writes
// (X at BASE_ADDR, Y at BASE_ADDR+1, DATA at BASE_ADDR+2). X and Y writes are
// skipped when they repeat the last value written, so a stream of pixels on
// one coordinate costs a single DATA write each.
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake; ready = FIFO not full
//   req_x, req_y, req_pixel    pixel column, row and value
//   bus_addr/bus_data/bus_we   registered bus write port, one strobe per write
//   busy                       requests pending or a sequence in progress
//   drop                       one-cycle pulse for an accepted out-of-range request
module vga_pixel_bus_master
    import vga_bus_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR  = VGA_BASE_ADDR,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] X_MAX      = VGA_X_MAX,
    parameter logic [6:0] Y_MAX      = VGA_Y_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_x,
    input  logic [6:0] req_y,
    input  logic       req_pixel,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_data,
    output logic       bus_we,
    output logic       busy,
    output logic       drop
);

    typedef enum logic [1:0] {SEL_NONE, SEL_X, SEL_Y, SEL_D} wr_sel_e;

    localparam logic [7:0] X_ADDR = BASE_ADDR + VGA_X_OFS;
    localparam logic [7:0] Y_ADDR = BASE_ADDR + VGA_Y_OFS;
    localparam logic [7:0] D_ADDR = BASE_ADDR + VGA_D_OFS;

    pixel_req_t fifo_wdata_s;
    pixel_req_t fifo_rdata_s;
    pixel_req_t work_r;
    logic       fifo_full_s;
    logic       fifo_empty_s;
    logic       fifo_pop_s;
    logic       accept_s;
    logic       in_range_s;
    logic       push_s;

    wr_state_e  state_r;
    wr_state_e  state_nx_s;
    wr_sel_e    sel_s;

    logic [7:0] shadow_x_r;
    logic [6:0] shadow_y_r;
    logic       shadow_x_vld_r;
    logic       shadow_y_vld_r;
    logic       x_hit_s;
    logic       y_hit_s;
    logic       set_x_s;
    logic       set_y_s;

    logic       we_s;
    logic [7:0] addr_s;
    logic [7:0] data_s;
    logic [7:0] bus_addr_r;
    logic [7:0] bus_data_r;
    logic       bus_we_r;
    logic       drop_r;

    // Ready depends only on registered FIFO state, never on req_valid.
    assign req_ready    = !fifo_full_s;
    assign accept_s     = req_valid && req_ready;
    assign in_range_s   = req_in_range(req_x, req_y, X_MAX, Y_MAX);
    assign push_s       = accept_s && in_range_s;
    assign fifo_wdata_s = '{x: req_x, y: req_y, pixel: req_pixel};

    pixel_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (fifo_wdata_s),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_rdata_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign x_hit_s = shadow_x_vld_r && (shadow_x_r == work_r.x);
    assign y_hit_s = shadow_y_vld_r && (shadow_y_r == work_r.y);

    // Sequencer: choose this cycle's write, chaining through skipped X/Y
    // writes in the same cycle so an unchanged coordinate costs no bus cycle.
    always_comb begin
        state_nx_s = state_r;
        sel_s      = SEL_NONE;
        fifo_pop_s = 1'b0;
        we_s       = 1'b0;
        addr_s     = bus_addr_r;
        data_s     = bus_data_r;
        set_x_s    = 1'b0;
        set_y_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    state_nx_s = ST_WR_X;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WR_X: begin
                if (!x_hit_s) begin
                    sel_s = SEL_X;
                end else if (!y_hit_s) begin
                    sel_s = SEL_Y;
                end else begin
                    sel_s = SEL_D;
                end
            end
            ST_WR_Y: begin
                if (!y_hit_s) begin
                    sel_s = SEL_Y;
                end else begin
                    sel_s = SEL_D;
                end
            end
            ST_WR_D: begin
                sel_s = SEL_D;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase

        case (sel_s)
            SEL_X: begin
                we_s       = 1'b1;
                addr_s     = X_ADDR;
                data_s     = work_r.x;
                set_x_s    = 1'b1;
                state_nx_s = ST_WR_Y;
            end
            SEL_Y: begin
                we_s       = 1'b1;
                addr_s     = Y_ADDR;
                data_s     = {1'b0, work_r.y};
                set_y_s    = 1'b1;
                state_nx_s = ST_WR_D;
            end
            SEL_D: begin
                we_s   = 1'b1;
                addr_s = D_ADDR;
                data_s = {7'b0, work_r.pixel};
                // Back-to-back: fetch the next request while DATA goes out.
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    state_nx_s = ST_WR_X;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
    end

    // State, working request, shadows and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            work_r         <= '0;
            shadow_x_r     <= 8'd0;
            shadow_y_r     <= 7'd0;
            shadow_x_vld_r <= 1'b0;
            shadow_y_vld_r <= 1'b0;
            bus_addr_r     <= 8'd0;
            bus_data_r     <= 8'd0;
            bus_we_r       <= 1'b0;
            drop_r         <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            bus_addr_r <= addr_s;
            bus_data_r <= data_s;
            bus_we_r   <= we_s;
            drop_r     <= accept_s && !in_range_s;
            if (fifo_pop_s) begin
                work_r <= fifo_rdata_s;
            end
            if (set_x_s) begin
                shadow_x_r     <= work_r.x;
                shadow_x_vld_r <= 1'b1;
            end
            if (set_y_s) begin
                shadow_y_r     <= work_r.y;
                shadow_y_vld_r <= 1'b1;
            end
        end
    end

    assign bus_addr = bus_addr_r;
    assign bus_data = bus_data_r;
    assign bus_we   = bus_we_r;
    assign drop     = drop_r;
    assign busy     = !fifo_empty_s || (state_r != ST_IDLE);

endmodule

// File: tb/tb_vga_pixel_bus_master.sv
// Testbench for vga_pixel_bus_master. A reference model converts every
// accepted request into the list of bus writes it must produce (using the
// last-written X/Y values), a monitor checks each strobe against that list,
// and directed steps check latency, flow control, drops and reset.
module tb_vga_pixel_bus_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_x;
    logic [6:0] req_y;
    logic       req_pixel;
    logic [7:0] bus_addr;
    logic [7:0] bus_data;
    logic       bus_we;
    logic       busy;
    logic       drop;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int drop_seen = 0;
    int drop_exp  = 0;
    bit saw_full  = 1'b0;

    logic [15:0] exp_q[$];
    logic [15:0] log_q[$];
    int          strobe_cyc_q[$];

    bit         m_xv = 1'b0;
    bit         m_yv = 1'b0;
    logic [7:0] m_x  = 8'd0;
    logic [6:0] m_y  = 7'd0;

    vga_pixel_bus_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_pixel (req_pixel),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .bus_we    (bus_we),
        .busy      (busy),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Monitor: every strobe must be the next write the model predicts.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (drop === 1'b1) drop_seen++;
            if (bus_we === 1'b1) begin
                log_q.push_back({bus_addr, bus_data});
                strobe_cyc_q.push_back(cyc);
                check("strobe_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("strobe", 32'({bus_addr, bus_data}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Reference model: writes implied by one accepted request.
    task automatic model_accept(input logic [7:0] x, input logic [6:0] y, input logic p);
        if (x > 8'd159 || y > 7'd119) begin
            drop_exp++;
        end else begin
            if (!m_xv || m_x != x) begin
                exp_q.push_back({8'hB0, x});
                m_xv = 1'b1;
                m_x  = x;
            end
            if (!m_yv || m_y != y) begin
                exp_q.push_back({8'hB1, 1'b0, y});
                m_yv = 1'b1;
                m_y  = y;
            end
            exp_q.push_back({8'hB2, 7'd0, p});
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_log();
        log_q.delete();
        strobe_cyc_q.delete();
    endtask

    // Present one request; acc returns the number of the accepting edge.
    task automatic send(input logic [7:0] x, input logic [6:0] y, input logic p, output int acc);
        int bound;
        bound     = 0;
        req_valid = 1'b1;
        req_x     = x;
        req_y     = y;
        req_pixel = p;
        while (req_ready !== 1'b1 && bound < 200) begin
            saw_full = 1'b1;
            tick();
            bound++;
        end
        check("ready_wait", 32'(req_ready), 32'd1);
        @(posedge clk);
        model_accept(x, y, p);
        tick();
        acc       = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int b;
        b = 0;
        repeat (2) tick();
        while ((busy !== 1'b0 || exp_q.size() != 0) && b < 400) begin
            tick();
            b++;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int b;
        int d0;
        logic [7:0] rx;
        logic [6:0] ry;
        int r;

        // 1: reset held while a request is offered
        rst_n = 1'b0; req_valid = 1'b1; req_x = 8'd10; req_y = 7'd20; req_pixel = 1'b1;
        repeat (4) tick();
        check("rst_we",   32'(bus_we),   32'd0);
        check("rst_addr", 32'(bus_addr), 32'd0);
        check("rst_data", 32'(bus_data), 32'd0);
        check("rst_drop", 32'(drop),     32'd0);
        check("rst_busy", 32'(busy),     32'd0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", 32'(req_ready), 32'd1);
        repeat (3) tick();
        check("no_strobe_after_reset", 32'(log_q.size()), 32'd0);

        // 2: full three-write sequence with latency
        clear_log();
        send(8'd10, 7'd20, 1'b1, a);
        wait_idle("t2");
        check("t2_count", 32'(log_q.size()), 32'd3);
        if (log_q.size() == 3) begin
            check("t2_w0", 32'(log_q[0]), 32'h0000_B00A);
            check("t2_w1", 32'(log_q[1]), 32'h0000_B114);
            check("t2_w2", 32'(log_q[2]), 32'h0000_B201);
            check("t2_lat0", 32'(strobe_cyc_q[0]), 32'(a + 2));
            check("t2_lat1", 32'(strobe_cyc_q[1]), 32'(a + 3));
            check("t2_lat2", 32'(strobe_cyc_q[2]), 32'(a + 4));
        end

        // 3: redundant X/Y skipped
        clear_log();
        send(8'd10, 7'd20, 1'b0, a);
        wait_idle("t3a");
        check("t3a_count", 32'(log_q.size()), 32'd1);
        if (log_q.size() == 1) begin
            check("t3a_w0",   32'(log_q[0]), 32'h0000_B200);
            check("t3a_lat0", 32'(strobe_cyc_q[0]), 32'(a + 2));
        end
        clear_log();
        send(8'd11, 7'd20, 1'b1, a);
        wait_idle("t3b");
        check("t3b_count", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            check("t3b_w0",   32'(log_q[0]), 32'h0000_B00B);
            check("t3b_w1",   32'(log_q[1]), 32'h0000_B201);
            check("t3b_lat1", 32'(strobe_cyc_q[1]), 32'(a + 3));
        end

        // 4: back-to-back burst fills the FIFO, order preserved
        clear_log();
        saw_full = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(8'(40 + i), 7'd20, 1'(i % 2), a);
        end
        wait_idle("t4");
        check("t4_saw_full", 32'(saw_full), 32'd1);
        check("t4_count", 32'(log_q.size()), 32'd16);
        if (log_q.size() == 16) begin
            for (int i = 0; i < 8; i++) begin
                check("t4_x", 32'(log_q[2*i]),     32'({8'hB0, 8'(40 + i)}));
                check("t4_d", 32'(log_q[2*i + 1]), 32'({8'hB2, 8'(i % 2)}));
            end
        end

        // 5: out-of-range requests are dropped
        clear_log();
        d0 = drop_seen;
        send(8'd160, 7'd5, 1'b1, a);
        wait_idle("t5a");
        check("t5_drop_x", 32'(drop_seen - d0), 32'd1);
        send(8'd5, 7'd120, 1'b1, a);
        wait_idle("t5b");
        check("t5_drop_y", 32'(drop_seen - d0), 32'd2);
        check("t5_no_strobe", 32'(log_q.size()), 32'd0);
        send(8'd12, 7'd30, 1'b1, a);
        wait_idle("t5c");
        check("t5_full_seq", 32'(log_q.size()), 32'd3);

        // 6: reset between the X and Y strobes
        clear_log();
        send(8'd30, 7'd40, 1'b1, a);
        b = 0;
        while (strobe_cyc_q.size() == 0 && b < 50) begin
            tick();
            b++;
        end
        check("t6_first", 32'(log_q.size() > 0 ? log_q[0] : 16'h0), 32'h0000_B01E);
        rst_n = 1'b0;
        #1;
        check("t6_rst_we",   32'(bus_we),   32'd0);
        check("t6_rst_addr", 32'(bus_addr), 32'd0);
        check("t6_rst_data", 32'(bus_data), 32'd0);
        check("t6_rst_busy", 32'(busy),     32'd0);
        exp_q.delete();
        m_xv = 1'b0;
        m_yv = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        clear_log();
        send(8'd30, 7'd40, 1'b1, a);
        wait_idle("t6");
        check("t6_count", 32'(log_q.size()), 32'd3);
        if (log_q.size() == 3) begin
            check("t6_w0", 32'(log_q[0]), 32'h0000_B01E);
            check("t6_w1", 32'(log_q[1]), 32'h0000_B128);
            check("t6_w2", 32'(log_q[2]), 32'h0000_B201);
        end

        // Random traffic with frequent coordinate repeats and some drops
        for (int i = 0; i < 80; i++) begin
            r  = int'($urandom_range(0, 9));
            rx = (r < 6) ? 8'(50 + $urandom_range(0, 1)) :
                 (r < 9) ? 8'($urandom_range(0, 159)) : 8'($urandom_range(160, 255));
            r  = int'($urandom_range(0, 9));
            ry = (r < 6) ? 7'(60 + $urandom_range(0, 1)) :
                 (r < 9) ? 7'($urandom_range(0, 119)) : 7'($urandom_range(120, 127));
            send(rx, ry, 1'($urandom_range(0, 1)), a);
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_idle("rand");
        check("drop_total", 32'(drop_seen), 32'(drop_exp));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
